// File: rtl/act_packer.sv
// Requantizes Q3.12 activation results to unsigned Q0.8 (round-half-up, saturating)
// and packs LANES results per output word with valid/ready handshakes on both sides.
module act_packer #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_keep,
    output logic                 out_last,
    output logic [CNT_W-1:0]     sat_cnt
);

    localparam int IDX_W = $clog2(LANES);

    logic [IDX_W-1:0]   r_idx;
    logic [8*LANES-1:0] r_acc_data;
    logic [LANES-1:0]   r_acc_keep;
    logic               r_out_valid;
    logic [8*LANES-1:0] r_out_data;
    logic [LANES-1:0]   r_out_keep;
    logic               r_out_last;
    logic [CNT_W-1:0]   r_sat_cnt;

    logic [15:0]        w_sum;
    logic               w_ovf;
    logic               w_sat;
    logic [7:0]         w_q;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_complete;
    logic [8*LANES-1:0] w_word_data;
    logic [LANES-1:0]   w_word_keep;
    logic               w_unused;

    // Adding half an output LSB (8 in Q3.12) before truncation gives round-half-up;
    // any carry into the integer bits means the result no longer fits in Q0.8.
    assign w_sum    = {1'b0, in_data[14:0]} + 16'd8;
    assign w_ovf    = (w_sum[15:12] != 4'd0);
    assign w_sat    = in_data[15] | w_ovf;
    assign w_q      = in_data[15] ? 8'h00 : (w_ovf ? 8'hFF : w_sum[11:4]);
    assign w_unused = &{1'b0, w_sum[3:0]};

    assign in_ready   = !rst && (!r_out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_complete = w_in_fire && ((r_idx == IDX_W'(LANES - 1)) || in_last);

    // Accumulator with the current beat merged into lane r_idx.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_word_data[gi*8 +: 8] = (r_idx == IDX_W'(gi)) ? w_q : r_acc_data[gi*8 +: 8];
            assign w_word_keep[gi]        = (r_idx == IDX_W'(gi)) ? 1'b1 : r_acc_keep[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_acc_data  <= '0;
            r_acc_keep  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_sat_cnt   <= '0;
        end else begin
            if (w_complete) begin
                r_out_data  <= w_word_data;
                r_out_keep  <= w_word_keep;
                r_out_last  <= in_last;
                r_out_valid <= 1'b1;
                r_idx       <= '0;
                r_acc_data  <= '0;
                r_acc_keep  <= '0;
            end else begin
                if (w_out_fire) begin
                    r_out_valid <= 1'b0;
                end
                if (w_in_fire) begin
                    r_acc_data <= w_word_data;
                    r_acc_keep <= w_word_keep;
                    r_idx      <= r_idx + 1'b1;
                end
            end
            // Counter sticks at all-ones so a long run never reads as a low count.
            if (w_in_fire && w_sat && (r_sat_cnt != {CNT_W{1'b1}})) begin
                r_sat_cnt <= r_sat_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_act_packer.sv
// Directed self-checking bench for act_packer: rounding, packing, flush,
// backpressure, saturation counting and mid-vector reset.
module tb_act_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] sat_cnt;

    // Narrow-counter copy sharing the same stimulus, used to reach the sticky limit.
    logic        in_ready_s;
    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [3:0]  out_keep_s;
    logic        out_last_s;
    logic [2:0]  sat_cnt_s;

    act_packer #(.LANES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .sat_cnt(sat_cnt)
    );

    act_packer #(.LANES(4), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_keep(out_keep_s),
        .out_last(out_last_s), .sat_cnt(sat_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          cyc;
    } word_t;

    word_t mon_q[$];
    int    cyc    = 0;
    int    tests  = 0;
    int    failed = 0;
    int    stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture each output transfer in the middle of the low phase.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            mon_q.push_back('{data: out_data, keep: out_keep, last: out_last, cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 50) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                               input logic l, output int stamp);
        word_t w;
        int n;
        n = 0;
        while (mon_q.size() == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (mon_q.size() == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            stamp = -1;
        end else begin
            w = mon_q.pop_front();
            $display("[TB] %s word data=0x%08h keep=0x%0h last=%0d cyc=%0d", tag, w.data, w.keep, w.last, w.cyc);
            check({tag, "_data"}, 64'(w.data), 64'(d));
            check({tag, "_keep"}, 64'(w.keep), 64'(k));
            check({tag, "_last"}, 64'(w.last), 64'(l));
            stamp = w.cyc;
        end
    endtask

    initial begin
        int s0, s1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        rst = 1'b0;

        // Rounding / saturation boundaries
        send(16'h0007, 1'b0);
        send(16'h0008, 1'b0);
        send(16'h0FF7, 1'b0);
        send(16'h0FF8, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("round_latency_valid", 64'(out_valid), 64'd1);
        expect_word("round", 32'hFFFF0100, 4'hF, 1'b1, s0);
        check("round_sat_cnt", 64'(sat_cnt), 64'd1);

        // Back-to-back streaming
        stalls = 0;
        send(16'h0800, 1'b0);
        send(16'h1000, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0A00, 1'b0);
        send(16'h0100, 1'b0);
        send(16'h0FF8, 1'b0);
        send(16'h8000, 1'b0);
        send(16'h0200, 1'b1);
        idle();
        expect_word("stream0", 32'hA000FF80, 4'hF, 1'b0, s0);
        expect_word("stream1", 32'h2000FF10, 4'hF, 1'b1, s1);
        check("stream_spacing", 64'(s1 - s0), 64'd4);
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_sat_cnt", 64'(sat_cnt), 64'd4);

        // Partial flush, then in_last on lane 0
        send(16'h0D80, 1'b0);
        send(16'h0400, 1'b1);
        send(16'h0100, 1'b1);
        idle();
        expect_word("partial", 32'h000040D8, 4'h3, 1'b1, s0);
        expect_word("lane0_last", 32'h00000010, 4'h1, 1'b1, s0);

        // Backpressure
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h0010, 1'b0);
        send(16'h0020, 1'b0);
        send(16'h0030, 1'b0);
        send(16'h0040, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0050;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'h04030201);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        idle();
        expect_word("bp_old", 32'h04030201, 4'hF, 1'b0, s0);
        expect_word("bp_new", 32'h00000005, 4'h1, 1'b1, s1);
        check("bp_spacing", 64'(s1 - s0), 64'd1);
        repeat (3) @(negedge clk);
        check("bp_no_dup", 64'(mon_q.size()), 64'd0);
        check("bp_sat_cnt", 64'(sat_cnt), 64'd4);

        // Negative input
        send(16'h8123, 1'b1);
        idle();
        expect_word("neg", 32'h00000000, 4'h1, 1'b1, s0);
        check("neg_sat_cnt", 64'(sat_cnt), 64'd5);

        // Reset mid-word
        send(16'h0FF8, 1'b0);
        send(16'h0FF8, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_out_data", 64'(out_data), 64'd0);
        check("mrst_out_keep", 64'(out_keep), 64'd0);
        check("mrst_sat_cnt", 64'(sat_cnt), 64'd0);
        rst = 1'b0;
        send(16'h0010, 1'b0);
        send(16'h0020, 1'b0);
        send(16'h0030, 1'b0);
        send(16'h0040, 1'b0);
        idle();
        expect_word("post_rst", 32'h04030201, 4'hF, 1'b0, s0);

        // Sticky saturation counter
        for (int i = 0; i < 12; i++) send(16'h1000, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) expect_word("sat_word", 32'hFFFFFFFF, 4'hF, 1'b0, s0);
        check("sat_cnt_12", 64'(sat_cnt), 64'd12);
        check("sat_cnt_sticky", 64'(sat_cnt_s), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
